// File: rtl/eh2_pkg.sv
// Core configuration parameters shared by EH2 LSU blocks.
// Only the fields needed by the DCCM write buffer are carried here.
package eh2_pkg;

  typedef struct packed {
    int DCCM_BITS;
    int DCCM_FDATA_WIDTH;
  } eh2_param_t;

  localparam eh2_param_t PARAM_DEFAULT = '{DCCM_BITS: 16, DCCM_FDATA_WIDTH: 39};

endpackage

// File: rtl/eh2_lsu_dccm_wrbuf.sv
// DCCM store write buffer: circular FIFO with youngest-entry coalescing,
// read forwarding and opportunistic drain that yields to LSU reads until starved.
module eh2_lsu_dccm_wrbuf
  import eh2_pkg::*;
#(
  parameter eh2_param_t pt         = PARAM_DEFAULT,
  parameter int         DEPTH      = 4,
  parameter int         STARVE_MAX = 7
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [pt.DCCM_BITS-1:0]        wr_addr,
  input  logic [pt.DCCM_FDATA_WIDTH-1:0] wr_data,
  input  logic                           flush_req,
  input  logic                           rd_req,
  input  logic [pt.DCCM_BITS-1:0]        rd_addr,
  output logic                           rd_hit,
  output logic [pt.DCCM_FDATA_WIDTH-1:0] rd_fwd_data,
  output logic                           rd_blocked,
  output logic                           dccm_wren,
  output logic [pt.DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [pt.DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [pt.DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [pt.DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  output logic                           empty
);

  localparam int AW = pt.DCCM_BITS;
  localparam int DW = pt.DCCM_FDATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [2:0]    STARVE_C = 3'(STARVE_MAX);

  logic [CW-1:0] count_reg;
  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [2:0]    starve_reg;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic          full;
  logic          accept;
  logic          drain;
  logic          coalesce;
  logic          push;
  logic [PW-1:0] youngest_idx;
  logic [PW-1:0] wr_idx;

  assign full         = (count_reg == DEPTH_C);
  assign wr_ready     = (count_reg < DEPTH_C) & ~flush_req;
  assign accept       = wr_valid & wr_ready;
  assign youngest_idx = tail_reg - PW'(1);

  assign drain = (count_reg != '0) &
                 (~rd_req | full | flush_req | (starve_reg == STARVE_C));

  // A lone entry leaving this cycle cannot absorb the new store; it is pushed behind it.
  assign coalesce = accept & (count_reg != '0) &
                    (addr_mem[youngest_idx] == wr_addr) &
                    ~(drain & (count_reg == CW'(1)));
  assign push     = accept & ~coalesce;
  assign wr_idx   = coalesce ? youngest_idx : tail_reg;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_reg  <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
      starve_reg <= '0;
    end else begin
      if (push)
        tail_reg <= tail_reg + PW'(1);
      if (drain)
        head_reg <= head_reg + PW'(1);

      if (push && !drain)
        count_reg <= count_reg + CW'(1);
      else if (!push && drain)
        count_reg <= count_reg - CW'(1);

      if ((count_reg == '0) || drain)
        starve_reg <= '0;
      else if (rd_req && (starve_reg != STARVE_C))
        starve_reg <= starve_reg + 3'd1;
    end
  end

  // Entry storage carries no reset; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Per-age match, oldest at age 0, so the highest matching age is the youngest store.
  logic [DEPTH-1:0] age_match;
  logic [DW-1:0]    age_data [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] idx;
    assign idx           = head_reg + PW'(gi);
    assign age_match[gi] = (CW'(gi) < count_reg) && (addr_mem[idx] == rd_addr);
    assign age_data[gi]  = data_mem[idx];
  end

  logic          fwd_hit_next;
  logic [DW-1:0] fwd_data_next;

  always_comb begin
    fwd_hit_next  = 1'b0;
    fwd_data_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_match[k]) begin
        fwd_hit_next  = 1'b1;
        fwd_data_next = age_data[k];
      end
    end
  end

  assign rd_hit      = rd_req & fwd_hit_next;
  assign rd_fwd_data = rd_hit ? fwd_data_next : '0;
  assign rd_blocked  = rd_req & drain;

  assign dccm_wren       = drain;
  assign dccm_wr_addr_lo = drain ? addr_mem[head_reg] : '0;
  assign dccm_wr_addr_hi = drain ? addr_mem[head_reg] : '0;
  assign dccm_wr_data_lo = drain ? data_mem[head_reg] : '0;
  assign dccm_wr_data_hi = drain ? data_mem[head_reg] : '0;

  assign empty = (count_reg == '0);

endmodule
